pingpong_bank_scheduler: RTL and testbench

Sequences the two-bank 1-bit frame buffer between the camera capture writer (cam_pclk domain) and the MCU-side reader (clk domain). Runs entirely on the 48 MHz system clock. Detects completed camera frames, selects which bank the camera writes, grants finished frames to the reader, and drops frames when the reader is slow. Outputs drive bank-select muxing around the SPRAM pair and the reader's buffer_ready/frame_read_complete handshake.

---
 rtl/camera_pkg.sv | 18 +
 rtl/pingpong_bank_scheduler_sync.sv | 28 ++
 rtl/pingpong_bank_scheduler.sv | 142 ++++++++++++++
 tb/tb_pingpong_bank_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/camera_pkg.sv
// Shared types and defaults for the camera frame-buffer scheduling blocks.
// Optional reader watchdog is enabled with FRAME_TIMEOUT_EN.
package camera_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READY,
      READING
   } sched_state_t;

   typedef logic bank_t;

   localparam int SEQ_W_DEF          = 8;
   localparam int DROP_W_DEF         = 8;
   localparam int TIMEOUT_CYCLES_DEF = 4_800_000;
   localparam int TMO_W_DEF          = 23;

endpackage

// File: rtl/pingpong_bank_scheduler_sync.sv
// Toggle-to-pulse crossing: 2-FF synchronizer plus an edge flop.
// Each edge of tog_i gives one frame_evt_o cycle on clk_i.
module toggle_sync_pulse (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tog_i,
   output logic frame_evt_o
);

   logic s1_q;
   logic s2_q;
   logic s3_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= tog_i;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign frame_evt_o = s2_q ^ s3_q;

endmodule

// File: rtl/pingpong_bank_scheduler.sv
// Two-bank frame buffer scheduler between camera writer and MCU reader.
// Define FRAME_TIMEOUT_EN to add the reader watchdog (rd_timeout).
module pingpong_bank_scheduler
   import camera_pkg::*;
#(
   parameter int SEQ_W          = SEQ_W_DEF,
   parameter int DROP_W         = DROP_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int TMO_W          = TMO_W_DEF
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              cam_frame_toggle,
   input  logic              rd_req,
   input  logic              rd_done,
   output logic              wr_bank,
   output logic              rd_bank,
   output logic              buffer_ready,
   output logic              reading,
   output logic [SEQ_W-1:0]  frame_seq,
   output logic [DROP_W-1:0] drop_count,
   output logic              rd_timeout
);

   if (2 ** TMO_W <= TIMEOUT_CYCLES) begin : g_bad_tmo_w
      $error("TMO_W too narrow for TIMEOUT_CYCLES");
   end

   sched_state_t      state_q, state_d;
   bank_t             wr_q, wr_d;
   logic [SEQ_W-1:0]  seq_q, seq_d;
   logic [DROP_W-1:0] drop_q, drop_d;
   logic              br_q, rdg_q;
   logic              frame_evt;
   logic              tmo_exp;
   logic              swap;
   logic              drop;
   logic              rd_end;

   toggle_sync_pulse u_sync (
      .clk_i       (clk),
      .rst_ni      (nreset),
      .tog_i       (cam_frame_toggle),
      .frame_evt_o (frame_evt)
   );

`ifdef FRAME_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             tmo_pulse_q;

   // Held at zero outside READING so the first READING cycle counts from 0.
   always_comb begin
      tmo_d = '0;
      if (state_q == READING) tmo_d = tmo_q + 1'b1;
   end

   assign tmo_exp = (state_q == READING) && (tmo_q == TMO_LAST) && !rd_done;

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tmo_q       <= '0;
         tmo_pulse_q <= 1'b0;
      end else begin
         tmo_q       <= tmo_d;
         tmo_pulse_q <= tmo_exp;
      end
   end

   assign rd_timeout = tmo_pulse_q;
`else
   assign tmo_exp    = 1'b0;
   assign rd_timeout = 1'b0;
`endif

   assign rd_end = rd_done | tmo_exp;

   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      seq_d   = seq_q;
      drop_d  = drop_q;
      swap    = 1'b0;
      drop    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (frame_evt) begin
               swap    = 1'b1;
               state_d = READY;
            end
         end
         READY: begin
            if (frame_evt) begin
               swap = 1'b1;
               drop = 1'b1;
            end
            if (rd_req) state_d = READING;
         end
         READING: begin
            if (rd_end) begin
               swap    = frame_evt;
               state_d = frame_evt ? READY : IDLE;
            end else if (frame_evt) begin
               drop = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (swap) begin
         wr_d  = ~wr_q;
         seq_d = seq_q + 1'b1;
      end
      if (drop && (drop_q != {DROP_W{1'b1}})) drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         seq_q   <= '0;
         drop_q  <= '0;
         br_q    <= 1'b0;
         rdg_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         seq_q   <= seq_d;
         drop_q  <= drop_d;
         br_q    <= (state_d == READY);
         rdg_q   <= (state_d == READING);
      end
   end

   assign wr_bank      = wr_q;
   assign rd_bank      = ~wr_q;
   assign buffer_ready = br_q;
   assign reading      = rdg_q;
   assign frame_seq    = seq_q;
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_pingpong_bank_scheduler.sv
// Scoreboard bench for pingpong_bank_scheduler (default and FRAME_TIMEOUT_EN builds).
`timescale 1ns/1ps
module tb_pingpong_bank_scheduler;

`ifdef FRAME_TIMEOUT_EN
   localparam int TB_TMO = 16;
`else
   localparam int TB_TMO = 4_800_000;
`endif

   localparam int M_IDLE = 0;
   localparam int M_READY = 1;
   localparam int M_READING = 2;

   typedef struct {
      logic       wr;
      logic       rd;
      logic       br;
      logic       rdg;
      logic [7:0] seq;
      logic [7:0] drop;
      logic       tmo;
   } exp_t;

   logic       clk = 1'b0;
   logic       nreset;
   logic       cam;
   logic       rd_req;
   logic       rd_done;
   logic       wr_bank;
   logic       rd_bank;
   logic       buffer_ready;
   logic       reading;
   logic [7:0] frame_seq;
   logic [7:0] drop_count;
   logic       rd_timeout;

   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb_q[$];

   int       m_state;
   logic     m_wr;
   int       m_seq;
   int       m_drop;

   pingpong_bank_scheduler #(
      .SEQ_W          (8),
      .DROP_W         (8),
      .TIMEOUT_CYCLES (TB_TMO),
      .TMO_W          (23)
   ) dut (
      .clk              (clk),
      .nreset           (nreset),
      .cam_frame_toggle (cam),
      .rd_req           (rd_req),
      .rd_done          (rd_done),
      .wr_bank          (wr_bank),
      .rd_bank          (rd_bank),
      .buffer_ready     (buffer_ready),
      .reading          (reading),
      .frame_seq        (frame_seq),
      .drop_count       (drop_count),
      .rd_timeout       (rd_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void m_reset();
      m_state = M_IDLE;
      m_wr    = 1'b0;
      m_seq   = 0;
      m_drop  = 0;
   endfunction

   function automatic void m_step(input bit evt, input bit rq, input bit dn);
      bit sw = 0;
      bit dr = 0;
      case (m_state)
         M_IDLE: if (evt) begin sw = 1; m_state = M_READY; end
         M_READY: begin
            if (evt) begin sw = 1; dr = 1; end
            if (rq) m_state = M_READING;
         end
         default: begin
            if (dn) begin
               sw = evt;
               m_state = evt ? M_READY : M_IDLE;
            end else if (evt) dr = 1;
         end
      endcase
      if (sw) begin
         m_wr  = ~m_wr;
         m_seq = (m_seq + 1) % 256;
      end
      if (dr && m_drop < 255) m_drop++;
   endfunction

   task automatic push_model();
      exp_t e;
      e.wr   = m_wr;
      e.rd   = ~m_wr;
      e.br   = (m_state == M_READY);
      e.rdg  = (m_state == M_READING);
      e.seq  = 8'(m_seq);
      e.drop = 8'(m_drop);
      e.tmo  = 1'b0;
      sb_q.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
         return;
      end
      e = sb_q.pop_front();
      chk({tag, "_wr"}, wr_bank, e.wr);
      chk({tag, "_rd"}, rd_bank, e.rd);
      chk({tag, "_br"}, buffer_ready, e.br);
      chk({tag, "_rdg"}, reading, e.rdg);
      chk({tag, "_seq"}, frame_seq, e.seq);
      chk({tag, "_drop"}, drop_count, e.drop);
      chk({tag, "_tmo"}, rd_timeout, e.tmo);
   endtask

   // Toggle, then hold rq/dn across the edge that sees frame_evt.
   task automatic frame_step(input string tag, input bit rq, input bit dn);
      @(negedge clk);
      cam = ~cam;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_lat"}, wr_bank, m_wr);
      rd_req  = rq;
      rd_done = dn;
      m_step(1, rq, dn);
      push_model();
      @(posedge clk);
      @(negedge clk);
      rd_req  = 1'b0;
      rd_done = 1'b0;
      pop_check(tag);
   endtask

   task automatic pulse(input string tag, input bit rq, input bit dn);
      @(negedge clk);
      rd_req  = rq;
      rd_done = dn;
      m_step(0, rq, dn);
      push_model();
      @(posedge clk);
      @(negedge clk);
      rd_req  = 1'b0;
      rd_done = 1'b0;
      pop_check(tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "bench watchdog");
   end

   initial begin
      nreset  = 1'b0;
      cam     = 1'b0;
      rd_req  = 1'b0;
      rd_done = 1'b0;
      m_reset();
      #12 nreset = 1'b1;
      @(negedge clk);
      push_model();
      pop_check("reset");

      frame_step("first", 0, 0);
      for (int i = 0; i < 3; i++) frame_step("overrun", 0, 0);

      pulse("claim", 1, 0);
      frame_step("rd_frz0", 0, 0);
      frame_step("rd_frz1", 0, 0);
      pulse("release", 0, 1);
      frame_step("refill", 0, 0);

      pulse("ign_done", 0, 1);
      frame_step("evt_req", 1, 0);
      pulse("ign_req", 1, 0);
      frame_step("evt_done", 0, 1);

      for (int i = 0; i < 260; i++) frame_step("sat", 0, 0);

      pulse("claim2", 1, 0);
      @(negedge clk);
      #2;
      nreset = 1'b0;
      cam    = 1'b0;
      m_reset();
      push_model();
      #1;
      pop_check("async_rst");
      @(negedge clk);
      #2 nreset = 1'b1;
      @(negedge clk);
      push_model();
      pop_check("post_rst");

      frame_step("pre_tmo", 0, 0);
      pulse("claim3", 1, 0);
`ifdef FRAME_TIMEOUT_EN
      begin
         int cyc = 0;
         bit seen = 0;
         while (cyc < 100 && !seen) begin
            @(posedge clk);
            cyc++;
            #1;
            seen = rd_timeout;
         end
         chk("tmo_seen", seen, 1);
         chk("tmo_cycles", cyc, 16);
         @(posedge clk);
         #1;
         m_state = M_IDLE;
         push_model();
         pop_check("tmo_after");
      end
`else
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         chk("no_tmo", rd_timeout, 0);
      end
      push_model();
      pop_check("still_rd");
      pulse("release3", 0, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
